// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared types, constants and BCD helpers for stopwatch_core.
//   BCD_W / DIGITS : display digit width and count (6 nibbles: mm:ss.cc)
//   sw_state_e     : IDLE / RUN / PAUSE state encoding
//   time_inc()     : one-centisecond BCD increment with carries
//   max_time()     : BCD value of MAX_MIN:59.99
package stopwatch_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned DIGITS   = 6;
    localparam int unsigned DISP_W   = BCD_W * DIGITS;
    localparam int unsigned DB_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    typedef logic [BCD_W-1:0]  bcd_t;
    typedef logic [DISP_W-1:0] sw_time_t;

    // Roll-over value of each digit: {min_t, min_o, sec_t, sec_o, cs_t, cs_o}.
    localparam sw_time_t DIGIT_LIMIT = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    // Ripple a +1 through the digits; a digit at or above its limit wraps to
    // zero, so an illegal nibble can never persist.
    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t r;
        logic     carry;
        bcd_t     d;
        bcd_t     lim;
        r     = t;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d   = t[i*BCD_W +: BCD_W];
            lim = DIGIT_LIMIT[i*BCD_W +: BCD_W];
            if (carry) begin
                if (d >= lim) begin
                    r[i*BCD_W +: BCD_W] = '0;
                end else begin
                    r[i*BCD_W +: BCD_W] = d + bcd_t'(1);
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic sw_time_t max_time(input int unsigned max_min);
        return {bcd_t'(max_min / 10), bcd_t'(max_min % 10),
                4'd5, 4'd9, 4'd9, 4'd9};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce -- tick-sampled push-button debouncer with press-edge detect.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   tick   : one-cycle sample strobe
//   btn    : raw, bouncy, asynchronous button (active-high)
//   press  : one-cycle pulse on an accepted 0->1 level change; it is
//            combinational from tick so it always coincides with a tick
module sw_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_TICKS - 1);

    logic [1:0]          btn_sync;
    logic                level;
    logic [DB_CNT_W-1:0] cnt;
    logic                differ;
    logic                accept;

    // cnt counts consecutive tick samples that disagree with the accepted
    // level; any agreeing sample restarts the run.
    always_comb begin
        differ = (btn_sync[1] != level);
        accept = tick && differ && (cnt == LAST);
        press  = accept && btn_sync[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            level    <= 1'b0;
            cnt      <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn};
            if (tick) begin
                if (!differ) begin
                    cnt <= '0;
                end else if (accept) begin
                    level <= btn_sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core -- mm:ss.cc BCD stopwatch with start/stop and lap/clear.
// Ports:
//   clk_50MHz : system clock (only clock)
//   rst_n     : asynchronous active-low reset
//   clk_100Hz : 100 Hz square wave, sampled as data
//   btn_start : raw start/stop button
//   btn_lap   : raw lap/clear button
//   disp_bcd  : {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, registered
//   running   : high while in RUN, registered
//   lap_hold  : display frozen on the captured lap value
//   ovf       : sticky, count reached MAX_MIN:59.99
// Build option: define STOPWATCH_LAP_EN to include the lap register; without
// it lap_hold is tied low and lap presses in RUN are ignored.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_TICKS = 3,
    parameter int unsigned MAX_MIN  = 59
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic              clk_100Hz,
    input  logic              btn_start,
    input  logic              btn_lap,
    output logic [DISP_W-1:0] disp_bcd,
    output logic              running,
    output logic              lap_hold,
    output logic              ovf
);

    localparam sw_time_t MAX_TIME = max_time(MAX_MIN);

    logic [2:0] hz_sync;
    logic       tick;
    logic       start_press;
    logic       lap_press;
    sw_state_e  state_q;
    sw_state_e  state_d;
    sw_time_t   count_q;
    sw_time_t   count_d;
    sw_time_t   shown;
    logic       ovf_d;

    // Two synchroniser flops plus one history flop; tick is registered so it
    // appears three clocks after the 100 Hz rising edge.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            hz_sync <= '0;
            tick    <= 1'b0;
        end else begin
            hz_sync <= {hz_sync[1:0], clk_100Hz};
            tick    <= hz_sync[1] & ~hz_sync[2];
        end
    end

    sw_debounce #(.DB_TICKS(DB_TICKS)) u_db_start (
        .clk   (clk_50MHz),
        .rst_n (rst_n),
        .tick  (tick),
        .btn   (btn_start),
        .press (start_press)
    );

    sw_debounce #(.DB_TICKS(DB_TICKS)) u_db_lap (
        .clk   (clk_50MHz),
        .rst_n (rst_n),
        .tick  (tick),
        .btn   (btn_lap),
        .press (lap_press)
    );

`ifdef STOPWATCH_LAP_EN
    sw_time_t lap_q;
    sw_time_t lap_d;
    logic     hold_d;
`endif

    // Counting and transitions both look at the pre-transition state; a
    // start press wins over a lap press in the same cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf;
`ifdef STOPWATCH_LAP_EN
        lap_d   = lap_q;
        hold_d  = lap_hold;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_press) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    if (count_q == MAX_TIME) begin
                        ovf_d   = 1'b1;
                        state_d = ST_PAUSE;
                    end else begin
                        count_d = time_inc(count_q);
                    end
                end
                if (start_press) begin
                    state_d = ST_PAUSE;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_press) begin
                    hold_d = ~lap_hold;
                    if (!lap_hold) lap_d = count_q;
                end
`endif
            end
            ST_PAUSE: begin
                if (start_press) begin
                    state_d = ST_RUN;
                end else if (lap_press) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
                    hold_d  = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            ovf      <= 1'b0;
            running  <= 1'b0;
            disp_bcd <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf      <= ovf_d;
            running  <= (state_d == ST_RUN);
            disp_bcd <= shown;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            lap_q    <= '0;
            lap_hold <= 1'b0;
        end else begin
            lap_q    <= lap_d;
            lap_hold <= hold_d;
        end
    end

    always_comb shown = lap_hold ? lap_q : count_q;
`else
    always_comb begin
        lap_hold = 1'b0;
        shown    = count_q;
    end
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    localparam int unsigned DB   = 3;
    localparam int unsigned MAXM = 59;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_100Hz = 1'b0;
    logic        a_start = 1'b0, a_lap = 1'b0, b_start = 1'b0, b_lap = 1'b0;
    logic [23:0] a_disp, b_disp;
    logic        a_run, a_hold, a_ovf, b_run, b_hold, b_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    stopwatch_core #(.DB_TICKS(DB), .MAX_MIN(MAXM)) dut_a (
        .clk_50MHz (clk), .rst_n (rst_n), .clk_100Hz (clk_100Hz),
        .btn_start (a_start), .btn_lap (a_lap),
        .disp_bcd (a_disp), .running (a_run), .lap_hold (a_hold), .ovf (a_ovf)
    );

    stopwatch_core #(.DB_TICKS(DB), .MAX_MIN(0)) dut_b (
        .clk_50MHz (clk), .rst_n (rst_n), .clk_100Hz (clk_100Hz),
        .btn_start (b_start), .btn_lap (b_lap),
        .disp_bcd (b_disp), .running (b_run), .lap_hold (b_hold), .ovf (b_ovf)
    );

    always #10 clk = ~clk;

    // ---------------- reference model (instance A) ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_e;
    mstate_e m_state;
    int      m_cs, m_lap;
    bit      m_hold, m_ovf;
    bit      m_lvl[2];
    bit      m_last[2];
    int      m_runlen[2];
    localparam int MAX_CS = (MAXM * 60 + 59) * 100 + 99;

    function automatic void model_reset();
        m_state = M_IDLE; m_cs = 0; m_lap = 0; m_hold = 0; m_ovf = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 0; m_last[b] = 0; m_runlen[b] = 0;
        end
    endfunction

    // One 100 Hz tick with the given button levels.
    function automatic void model_step(input bit s, input bit l);
        bit      smp[2];
        bit      pr[2];
        mstate_e cur;
        int      old_cs;
        smp[0] = s; smp[1] = l;
        for (int b = 0; b < 2; b++) begin
            m_runlen[b] = (smp[b] == m_last[b]) ? m_runlen[b] + 1 : 1;
            m_last[b]   = smp[b];
            pr[b]       = 0;
            if (m_runlen[b] >= DB && smp[b] != m_lvl[b]) begin
                m_lvl[b] = smp[b];
                pr[b]    = smp[b];
            end
        end
        cur    = m_state;
        old_cs = m_cs;
        if (cur == M_RUN) begin
            if (m_cs == MAX_CS) begin
                m_ovf = 1; m_state = M_PAUSE;
            end else begin
                m_cs++;
            end
        end
        if (pr[0]) begin
            m_state = (cur == M_RUN) ? M_PAUSE : M_RUN;
        end else if (pr[1]) begin
            if (cur == M_RUN && LAP_EN) begin
                if (!m_hold) m_lap = old_cs;
                m_hold = !m_hold;
            end else if (cur == M_PAUSE) begin
                m_cs = 0; m_hold = 0; m_ovf = 0; m_state = M_IDLE;
            end
        end
    endfunction

    function automatic logic [23:0] to_bcd(input int cs);
        int mn, sc, c;
        mn = cs / 6000; sc = (cs / 100) % 60; c = cs % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    // ---------------- checking and stimulus helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, "/disp"}, 32'(a_disp), 32'(to_bcd(m_hold ? m_lap : m_cs)));
        check({name, "/running"}, 32'(a_run), 32'(m_state == M_RUN));
        check({name, "/lap_hold"}, 32'(a_hold), 32'(m_hold));
        check({name, "/ovf"}, 32'(a_ovf), 32'(m_ovf));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Buttons are held across the whole tick, so the tick samples them cleanly.
    task automatic slow_tick();
        clk_100Hz = 1'b1; cycles(3);
        clk_100Hz = 1'b0; cycles(3);
        model_step(a_start, a_lap);
    endtask

    task automatic fast_ticks(input int n);
        repeat (n) begin
            clk_100Hz = 1'b1; cycles(1);
            clk_100Hz = 1'b0; cycles(1);
            model_step(a_start, a_lap);
        end
        cycles(4);
    endtask

    task automatic press_a(input bit s, input bit l);
        a_start = s; a_lap = l;
        repeat (DB) slow_tick();
        a_start = 1'b0; a_lap = 1'b0;
        repeat (DB) slow_tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clk_100Hz = 1'b0;
        a_start = 0; a_lap = 0; b_start = 0; b_lap = 0;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        model_reset();
    endtask

    typedef struct {
        bit          start;
        bit          exp_run;
        logic [23:0] exp_disp;
    } vec_t;
    vec_t vecs[18];

    initial begin
        bit rs, rl;
        // Bounce for 10 ticks, then hold high: exactly one press, on row 12.
        for (int i = 0; i < 18; i++) begin
            vecs[i].start    = (i < 10) ? (i % 2 == 0) : (i < 15);
            vecs[i].exp_run  = (i >= 12);
            vecs[i].exp_disp = (i <= 12) ? 24'h0 : 24'(i - 12);
        end

        model_reset();
        #5;
        check("reset/disp", 32'(a_disp), 32'h0);
        check("reset/running", 32'(a_run), 32'h0);
        check("reset/lap_hold", 32'(a_hold), 32'h0);
        check("reset/ovf", 32'(a_ovf), 32'h0);
        do_reset();

        // Debounce table
        for (int i = 0; i < 18; i++) begin
            a_start = vecs[i].start;
            slow_tick();
            check($sformatf("table%0d/running", i), 32'(a_run), 32'(vecs[i].exp_run));
            check($sformatf("table%0d/disp", i), 32'(a_disp), 32'(vecs[i].exp_disp));
            check_model($sformatf("table%0d", i));
        end

        // Start press then 100 ticks
        do_reset();
        press_a(1, 0);
        fast_ticks(97);
        check("run100/disp", 32'(a_disp), 32'h000100);
        check("run100/running", 32'(a_run), 32'h1);
        check_model("run100");

        // Minute carries
        fast_ticks(5899);
        check("carry/005999", 32'(a_disp), 32'h005999);
        fast_ticks(1);
        check("carry/010000", 32'(a_disp), 32'h010000);
        fast_ticks(5999);
        check("carry/015999", 32'(a_disp), 32'h015999);
        fast_ticks(1);
        check("carry/020000", 32'(a_disp), 32'h020000);
        check_model("carry");

        // Asynchronous reset mid-RUN
        do_reset();
        press_a(1, 0);
        fast_ticks(1231);
        check("pre_rst/disp", 32'(a_disp), 32'h001234);
        rst_n = 1'b0;
        #2;
        check("async_rst/disp", 32'(a_disp), 32'h0);
        check("async_rst/running", 32'(a_run), 32'h0);
        check("async_rst/lap_hold", 32'(a_hold), 32'h0);
        check("async_rst/ovf", 32'(a_ovf), 32'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        model_reset();

        // Start and lap together in RUN
        press_a(1, 0);
        press_a(0, 1);
        check_model("pre_both");
        a_start = 1; a_lap = 1;
        repeat (DB) slow_tick();
        check("both/running", 32'(a_run), 32'h0);
        check("both/lap_hold", 32'(a_hold), 32'(LAP_EN));
        check_model("both");
        a_start = 0; a_lap = 0;
        repeat (DB) slow_tick();
        check_model("both_rel");

`ifdef STOPWATCH_LAP_EN
        // Lap capture and release
        do_reset();
        press_a(1, 0);
        fast_ticks(45);
        a_lap = 1;
        repeat (DB) slow_tick();
        check("lap1/disp", 32'(a_disp), 32'h000050);
        check("lap1/hold", 32'(a_hold), 32'h1);
        a_lap = 0;
        repeat (DB) slow_tick();
        fast_ticks(23);
        check("lap_frozen/disp", 32'(a_disp), 32'h000050);
        a_lap = 1;
        repeat (DB) slow_tick();
        check("lap2/disp", 32'(a_disp), 32'h000080);
        check("lap2/hold", 32'(a_hold), 32'h0);
        a_lap = 0;
        repeat (DB) slow_tick();
        check_model("lap2");
`endif

        // Randomized buttons against the model
        do_reset();
        rs = 0; rl = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) rs = ~rs;
            if ($urandom_range(5) == 0) rl = ~rl;
            a_start = rs; a_lap = rl;
            slow_tick();
            check_model($sformatf("rand%0d", i));
        end

        // Overflow with MAX_MIN = 0 (instance B)
        do_reset();
        b_start = 1;
        repeat (DB) slow_tick();
        b_start = 0;
        repeat (DB) slow_tick();
        fast_ticks(5996);
        check("ovfB/pre_disp", 32'(b_disp), 32'h005999);
        check("ovfB/pre_running", 32'(b_run), 32'h1);
        check("ovfB/pre_ovf", 32'(b_ovf), 32'h0);
        slow_tick();
        check("ovfB/ovf", 32'(b_ovf), 32'h1);
        check("ovfB/running", 32'(b_run), 32'h0);
        check("ovfB/disp", 32'(b_disp), 32'h005999);
        b_lap = 1;
        repeat (DB) slow_tick();
        check("clrB/disp", 32'(b_disp), 32'h0);
        check("clrB/ovf", 32'(b_ovf), 32'h0);
        check("clrB/running", 32'(b_run), 32'h0);
        check("clrB/lap_hold", 32'(b_hold), 32'h0);
        b_lap = 0;
        repeat (DB) slow_tick();
        b_start = 1;
        repeat (DB) slow_tick();
        b_start = 0;
        repeat (DB) slow_tick();
        check("restartB/disp", 32'(b_disp), 32'h000003);
        check("restartB/running", 32'(b_run), 32'h1);
        check_model("idleA");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
